// File: rtl/pattern_stream_sched.sv
// pattern_stream_sched: round-robin grant onto one shared overlapping 1010 detector; result FRAME_LEN cycles after gnt, frame period FRAME_LEN+2.
// Backpressure: result held in REPORT until done_ready, no grant meanwhile. PSS_HIT_STROBE_EN adds hit/hit_pos match strobes.
module pattern_stream_sched #(
   parameter int NREQ      = 4,
   parameter int FRAME_LEN = 16,
   parameter int CNT_W     = 5,
   localparam int IDX_W    = $clog2(NREQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*FRAME_LEN-1:0] req_word,
   output logic [NREQ-1:0]           gnt,
   output logic                      busy,
   output logic                      done_valid,
   output logic [IDX_W-1:0]          done_id,
   output logic [CNT_W-1:0]          done_count,
`ifdef PSS_HIT_STROBE_EN
   output logic                      hit,
   output logic [5:0]                hit_pos,
`endif
   input  logic                      done_ready
);

   typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
   typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

   state_t               state_q;
   det_t                 det_q, det_d;
   logic [NREQ-1:0]      gnt_q;
   logic [IDX_W-1:0]     ptr_q, pick_idx, pick_nxt, cand_idx, done_id_q;
   logic                 pick_vld;
   logic [FRAME_LEN-1:0] word_q;
   logic [5:0]           idx_q;
   logic [CNT_W-1:0]     cnt_q, cnt_d, done_count_q;
   logic                 busy_q, done_valid_q, bit_in, match;
`ifdef PSS_HIT_STROBE_EN
   logic                 hit_q;
   logic [5:0]           hit_pos_q;
`endif

   // The latched word shifts left each bit, so the bit under test is always the MSB.
   assign bit_in = word_q[FRAME_LEN-1];

   always_comb begin
      det_d = S0;
      match = 1'b0;
      case (det_q)
         S0: det_d = bit_in ? S1 : S0;
         S1: det_d = bit_in ? S1 : S2;
         S2: det_d = bit_in ? S3 : S0;
         S3: begin
            det_d = bit_in ? S1 : S2;
            match = !bit_in;
         end
         default: det_d = S0;
      endcase
      cnt_d = (match && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   // Scan offsets high to low so the nearest set bit at or above ptr wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand_idx = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         cand_idx = IDX_W'((int'(ptr_q) + k) % NREQ);
         if (req[cand_idx]) begin
            pick_vld = 1'b1;
            pick_idx = cand_idx;
         end
      end
      pick_nxt = (int'(pick_idx) == NREQ-1) ? '0 : pick_idx + IDX_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         gnt_q        <= '0;
         busy_q       <= 1'b0;
         done_valid_q <= 1'b0;
         done_id_q    <= '0;
         done_count_q <= '0;
         det_q        <= S0;
         word_q       <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
`ifdef PSS_HIT_STROBE_EN
         hit_q        <= 1'b0;
         hit_pos_q    <= '0;
`endif
      end else begin
         gnt_q <= '0;
`ifdef PSS_HIT_STROBE_EN
         hit_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (pick_vld) begin
                  word_q    <= req_word[int'(pick_idx)*FRAME_LEN +: FRAME_LEN];
                  gnt_q     <= NREQ'(1) << pick_idx;
                  det_q     <= S0;
                  cnt_q     <= '0;
                  idx_q     <= '0;
                  ptr_q     <= pick_nxt;
                  done_id_q <= pick_idx;
                  busy_q    <= 1'b1;
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               det_q  <= det_d;
               cnt_q  <= cnt_d;
               idx_q  <= idx_q + 6'd1;
               word_q <= word_q << 1;
`ifdef PSS_HIT_STROBE_EN
               if (match) begin
                  hit_q     <= 1'b1;
                  hit_pos_q <= idx_q;
               end
`endif
               if (idx_q == 6'(FRAME_LEN-1)) begin
                  done_count_q <= cnt_d;
                  done_valid_q <= 1'b1;
                  state_q      <= REPORT;
               end
            end
            REPORT: begin
               if (done_ready) begin
                  done_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt        = gnt_q;
   assign busy       = busy_q;
   assign done_valid = done_valid_q;
   assign done_id    = done_id_q;
   assign done_count = done_count_q;
`ifdef PSS_HIT_STROBE_EN
   assign hit        = hit_q;
   assign hit_pos    = hit_pos_q;
`endif

endmodule

// File: tb/tb_pattern_stream_sched.sv
// Bench for pattern_stream_sched: directed frame table, mid-frame reset, randomized frames vs. a window-count model, saturation on a CNT_W=2 instance.
module tb_pattern_stream_sched;

   localparam int NR = 4;
   localparam int FL = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [NR-1:0]   req, req2;
   logic [NR*FL-1:0] req_word, req_word2;
   logic [NR-1:0]   gnt, gnt2;
   logic            busy, busy2, done_valid, done_valid2, done_ready, done_ready2;
   logic [1:0]      done_id, done_id2;
   logic [4:0]      done_count;
   logic [1:0]      done_count2;
`ifdef PSS_HIT_STROBE_EN
   logic            hit, hit2;
   logic [5:0]      hit_pos, hit_pos2;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pattern_stream_sched #(.NREQ(NR), .FRAME_LEN(FL), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .req(req), .req_word(req_word), .gnt(gnt), .busy(busy),
      .done_valid(done_valid), .done_id(done_id), .done_count(done_count),
`ifdef PSS_HIT_STROBE_EN
      .hit(hit), .hit_pos(hit_pos),
`endif
      .done_ready(done_ready));

   pattern_stream_sched #(.NREQ(NR), .FRAME_LEN(FL), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .req(req2), .req_word(req_word2), .gnt(gnt2), .busy(busy2),
      .done_valid(done_valid2), .done_id(done_id2), .done_count(done_count2),
`ifdef PSS_HIT_STROBE_EN
      .hit(hit2), .hit_pos(hit_pos2),
`endif
      .done_ready(done_ready2));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: count every 4-bit window equal to 1010 (overlap is implicit), then saturate.
   function automatic int ref_count(input logic [15:0] w, input int cw);
      int n = 0;
      for (int p = 0; p + 4 <= 16; p++)
         if (w[15-p -: 4] == 4'b1010) n++;
      if (n > (1 << cw) - 1) n = (1 << cw) - 1;
      return n;
   endfunction

   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < NR; k++)
         if (r[(p + k) % NR]) return (p + k) % NR;
      return -1;
   endfunction

   task automatic apply_reset(input logic [3:0] r, input logic [63:0] w);
      @(negedge clk);
      rst = 1'b0; req = r; req_word = w; done_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Waits for the grant, then follows the frame through REPORT and the handshake.
   task automatic do_frame(input int exp_id, input int exp_cnt, input int stall,
                           input logic [3:0] req_after, input logic [63:0] words_after);
      int t = 0;
      done_ready = (stall == 0);
      while (gnt == '0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("gnt_onehot", gnt, 64'(1) << exp_id);
      check("gnt_lat", t, 1);
      check("busy_rise", busy, 1);
      req = req_after;
      req_word = words_after;
      for (int c = 1; c <= FL; c++) begin
         @(negedge clk);
         if (c == 1) check("gnt_pulse", gnt, 0);
         if (c == FL/2) check("busy_shift", busy, 1);
         if (c == FL-1) check("dv_early", done_valid, 0);
      end
      check("dv_rise", done_valid, 1);
      check("done_id", done_id, exp_id);
      check("done_count", done_count, exp_cnt);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check("hold_valid", done_valid, 1);
         check("hold_count", done_count, exp_cnt);
         check("hold_id", done_id, exp_id);
         check("hold_nogrant", gnt, 0);
      end
      done_ready = 1'b1;
      @(negedge clk);
      check("dv_fall", done_valid, 0);
      check("busy_fall", busy, 0);
   endtask

   typedef struct {
      logic        do_rst;
      logic [3:0]  req;
      logic [63:0] words;
      int          exp_id;
      int          exp_cnt;
      int          stall;
      logic [3:0]  req_after;
   } vec_t;

   vec_t tbl[8];

   initial begin
      logic [3:0]  cur_req, nr;
      logic [63:0] cur_words, nw;
      int          ptr_m, id, t;
      int          exp_hits[$];
      int          got_hits[$];

      tbl[0] = '{1'b1, 4'b0001, 64'h0000_0000_0000_AAAA, 0, 7, 0,  4'b0001};
      tbl[1] = '{1'b1, 4'b1111, 64'hD34A_AA00_0000_A000, 0, 1, 0,  4'b1111};
      tbl[2] = '{1'b0, 4'b1111, 64'hD34A_AA00_0000_A000, 1, 0, 0,  4'b1111};
      tbl[3] = '{1'b0, 4'b1111, 64'hD34A_AA00_0000_A000, 2, 3, 0,  4'b1111};
      tbl[4] = '{1'b0, 4'b1111, 64'hD34A_AA00_0000_A000, 3, 3, 0,  4'b1111};
      tbl[5] = '{1'b0, 4'b1111, 64'hD34A_AA00_0000_A000, 0, 1, 0,  4'b1111};
      tbl[6] = '{1'b0, 4'b0001, 64'hD34A_AA00_0000_A000, 0, 1, 10, 4'b0110};
      tbl[7] = '{1'b0, 4'b0110, 64'hD34A_AA00_0000_A000, 1, 0, 0,  4'b0110};

      rst = 1'b0; req = '0; req_word = '0; done_ready = 1'b0;
      req2 = '0; req_word2 = '0; done_ready2 = 1'b1;
      #1;
      check("rst_gnt", gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_dv", done_valid, 0);
      check("rst_id", done_id, 0);
      check("rst_count", done_count, 0);
`ifdef PSS_HIT_STROBE_EN
      check("rst_hit", hit, 0);
      check("rst_hit_pos", hit_pos, 0);
`endif
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_nogrant", gnt, 0);
         check("idle_busy", busy, 0);
      end

      for (int v = 0; v < 8; v++) begin
         if (tbl[v].do_rst) apply_reset(tbl[v].req, tbl[v].words);
         else begin
            req = tbl[v].req;
            req_word = tbl[v].words;
         end
         do_frame(tbl[v].exp_id, tbl[v].exp_cnt, tbl[v].stall, tbl[v].req_after, tbl[v].words);
      end

      // Reset in the middle of a frame: nothing is reported and the scan restarts at 0.
      apply_reset(4'b0010, 64'h0000_0000_AAAA_0000);
      t = 0;
      while (gnt == '0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("abort_gnt", gnt, 4'b0010);
      for (int i = 0; i < 8; i++) @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_dv", done_valid, 0);
      req = 4'b0101;
      req_word = 64'h0000_AAAA_0000_AAAA;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      check("abort_no_result", done_valid, 0);
      do_frame(0, 7, 0, 4'b0101, 64'h0000_AAAA_0000_AAAA);

      // Randomized frames against the round-robin / window-count model.
      cur_req = 4'($urandom_range(1, 15));
      cur_words = {$urandom, $urandom};
      apply_reset(cur_req, cur_words);
      ptr_m = 0;
      for (int f = 0; f < 40; f++) begin
         id = rr_pick(cur_req, ptr_m);
         nr = 4'($urandom_range(1, 15));
         nw = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) nw[16*$urandom_range(0, 3) +: 16] = 16'hAAAA;
         do_frame(id, ref_count(cur_words[id*16 +: 16], 5), $urandom_range(0, 3), nr, nw);
         ptr_m = (id + 1) % NR;
         cur_req = nr;
         cur_words = nw;
      end
      req = '0;

      // Saturating counter on the narrow instance.
      for (int p = 0; p + 4 <= 16; p++)
         if (ref_count(16'hAAAA >> (12 - p), 16) > ref_count(16'hAAAA >> (13 - p), 16)) exp_hits.push_back(p + 3);
      @(negedge clk);
      req2 = 4'b0001;
      req_word2 = 64'h0000_0000_0000_AAAA;
      t = 0;
      while (!done_valid2 && t < 60) begin
         @(negedge clk);
         t++;
`ifdef PSS_HIT_STROBE_EN
         if (hit2) got_hits.push_back(int'(hit_pos2));
`endif
      end
      req2 = '0;
      check("sat_valid", done_valid2, 1);
      check("sat_count", done_count2, ref_count(16'hAAAA, 2));
      check("sat_id", done_id2, 0);
`ifdef PSS_HIT_STROBE_EN
      check("hit_total", got_hits.size(), exp_hits.size());
      for (int i = 0; i < exp_hits.size() && i < got_hits.size(); i++)
         check("hit_pos", got_hits[i], exp_hits[i]);
`endif
      @(negedge clk);
      check("sat_dv_fall", done_valid2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pattern_stream_sched.md
# pattern_stream_sched

Round-robin scheduler that shares one 1010 Mealy sequence detector among NREQ requesters. Each requester presents a FRAME_LEN-bit word. The block grants one requester and latches its word, then shifts the word MSB-first through an internal overlapping 1010 detector at one bit per cycle. It returns the match count to the consumer over a valid/ready handshake. It sits between the requester front-ends and the result consumer, and is the only block that drives the shared detector.

## Interface
- NREQ, 4: number of requesters, 2..8.
- FRAME_LEN, 16: bits per frame, 4..32.
- CNT_W, 5: match-count width; the count saturates at all-ones.
- IDX_W, $clog2(NREQ): requester-id width (localparam).

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester request level.
- req_word  in  NREQ*FRAME_LEN  frame words; requester i occupies bits [i*FRAME_LEN +: FRAME_LEN].
- gnt  out  NREQ  one-hot, one-cycle pulse marking the cycle after the word was latched.
- busy  out  1  high in SHIFT and REPORT.
- done_valid  out  1  result available.
- done_id  out  IDX_W  index of the requester that owns the result.
- done_count  out  CNT_W  number of 1010 matches in the frame.
- done_ready  in  1  consumer accepts the result.

## Operation
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - On an edge with req != 0: pick the first set req bit scanning from ptr upward, with wrap.
  - On that edge: latch the word, set gnt[i] for the next cycle, clear det to S0, clear cnt and idx, set ptr = (i+1) mod NREQ, go to SHIFT.
  - req is sampled only in IDLE. A requester may drop req after its gnt pulse.
- SHIFT:
  - Each edge consumes bit word[FRAME_LEN-1-idx] and increments idx.
  - After the edge that consumes bit 0, go to REPORT.
- Detector states: S0 (nothing), S1 ("1"), S2 ("10"), S3 ("101").
  - S0: 1→S1, 0→S0.
  - S1: 1→S1, 0→S2.
  - S2: 1→S3, 0→S0.
  - S3: 1→S1, 0→S2 with match.
  - Detection is overlapping: the state after a match is S2.
- On a match: cnt increments and saturates at 2^CNT_W-1.
- REPORT:
  - done_valid=1; done_id and done_count are held stable.
  - On an edge with done_ready=1: go to IDLE and drop done_valid.
  - While done_valid is high, no new grant is made, regardless of req.
- Reset values: state=IDLE, ptr=0, gnt=0, busy=0, done_valid=0, done_id=0, done_count=0, det=S0.
- Reset asserted mid-operation: the in-flight frame is discarded, no result is emitted, and ptr returns to 0.

## Timing
- Edge E0 (IDLE, req != 0): gnt is high and busy rises during the E0→E1 cycle.
- Edges E1..E_FRAME_LEN consume the frame bits.
- done_valid rises after E_FRAME_LEN, i.e. FRAME_LEN cycles after gnt rises.
- Handshake edge: done_valid falls after it.
- Earliest next grant: the edge after the handshake edge.
- Minimum frame period with done_ready held high: FRAME_LEN+2 cycles.
- done_ready is don't-care outside REPORT.

## Configuration
- PSS_HIT_STROBE_EN defined:
  - Adds output hit (1 bit), high for one cycle after each match edge.
  - Adds output hit_pos (6 bits), holding the idx of the consumed bit at that match. Both are reset to 0.
- PSS_HIT_STROBE_EN undefined:
  - Neither port exists.
  - All other behaviour is identical.

## Test plan
- Reset with req=0: all outputs are 0; deassert reset and hold 20 cycles → no gnt, busy=0.
- req=4'b0001, word0=16'hAAAA, done_ready=1 → gnt=4'b0001; done_valid rises 16 cycles later with done_id=0, done_count=7.
- req=4'b1111, words 16'hA000/16'h0000/16'hAA00/16'hD34A, done_ready=1 → grant order 0,1,2,3,0; counts 1,0,3,3.
- done_ready=0 for 10 cycles in REPORT with req=4'b0110 → done_valid and done_count stable, no gnt; first gnt after the handshake goes to requester 1.
- Assert rst low at SHIFT bit 8, release, req=4'b0100 word 16'hAAAA → no result from the aborted frame; grant to requester 2 (ptr=0 scan); count=7.
- CNT_W=2, word 16'hAAAA → done_count=3 (saturated); with PSS_HIT_STROBE_EN, hit pulses 7 times at hit_pos 3,5,7,9,11,13,15.
